mstatus_ctrl: RTL and testbench
===============================

Name: mstatus_ctrl

Overview:
- Write/update side of the machine status CSR. It owns the mstatus state bits and the current privilege level.
- It applies CSR-instruction writes (write/set/clear), trap entry, MRET and SRET.
- It presents the packed 32-bit mstatus image to the CSR read mux and to downstream consumers: interrupt logic and MMU.
- It sits in the CSR unit between the decode/execute CSR port and the trap controller.

Parameters:
- SUPPORT_S, 1, supervisor mode implemented; when 0, SIE/SPIE/SPP/SUM/MXR/TVM/TSR read 0 and are not writable.
- SUPPORT_U, 1, user mode implemented; when 0, MPP is forced to 2'b11 and MPRV reads 0.
- RESET_PRIV, 2'b11, privilege level after reset.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous reset, active-low (asserted when 0)
- csr_valid  in  1  CSR write request; sampled only when csr_ready=1
- csr_ready  out  1  block can accept a CSR request
- csr_op  in  2  01=write, 10=set, 11=clear, 00=no-op (accepted, no change)
- csr_wdata  in  32  write operand
- csr_rdata  out  32  mstatus image captured at acceptance (pre-write value)
- csr_done  out  1  one-cycle pulse: captured write committed
- csr_drop  out  1  one-cycle pulse: captured write aborted by trap/xret
- trap_take  in  1  trap entry pulse
- mret  in  1  MRET retire pulse
- sret  in  1  SRET retire pulse
- sret_illegal  out  1  one-cycle pulse: SRET rejected (TSR=1 in S-mode, or priv=U)
- fs_dirty  in  1  FPU wrote FP state; sets FS=2'b11
- priv  out  2  current privilege (00 U, 01 S, 11 M)
- mstat  out  32  packed mstatus image

Behaviour:
- Bit layout:
  - SD[31], TSR[22], TW[21], TVM[20], MXR[19], SUM[18], MPRV[17], XS[16:15], FS[14:13], MPP[12:11], SPP[8], MPIE[7], SPIE[5], UPIE[4], MIE[3], SIE[1], UIE[0].
  - All other bits read 0.
- Fixed fields:
  - TW hardwired 0.
  - XS, UIE and UPIE read 0.
  - SD = (FS==2'b11) | (XS==2'b11), combinational.
- Reset (rst=0, asynchronous):
  - All stored bits 0, except MPP=2'b11.
  - priv=RESET_PRIV; mstat=32'h0000_1800.
  - csr_ready=1; csr_done, csr_drop and sret_illegal all 0.
  - FSM returns to IDLE mid-operation; a captured write is discarded without a csr_drop pulse.
- FSM states: IDLE, APPLY.
  - IDLE, csr_valid=1: capture op/wdata and the current mstat into csr_rdata; go to APPLY. csr_ready=0 in APPLY.
  - APPLY: compute new = write ? wdata : set ? old|wdata : clear ? old&~wdata : old.
  - APPLY: apply the writable mask and WARL rules, commit, pulse csr_done, return to IDLE. Total latency is 1 cycle from acceptance to commit.
  - APPLY with trap_take, mret or sret in the same cycle: the event wins, the write is not committed, csr_drop pulses, and the FSM returns to IDLE.
- WARL rules:
  - MPP write of 2'b10 keeps the old MPP.
  - MPP write of 2'b01 keeps the old MPP when SUPPORT_S=0.
  - Any MPP write other than 2'b11 keeps the old MPP when SUPPORT_U=0.
- Event priority (same cycle): trap_take > mret > sret > CSR commit > fs_dirty.
  - fs_dirty is still applied alongside any event or commit unless that commit writes FS explicitly.
- Trap entry: MPIE<=MIE, MIE<=0, MPP<=priv, priv<=11.
- MRET:
  - MIE<=MPIE, MPIE<=1, priv<=MPP.
  - MPP<=00 (or 11 when SUPPORT_U=0).
  - MPRV<=0 if the new priv is not 11.
- SRET, legal case (priv=11, or priv=01 with TSR=0):
  - SIE<=SPIE, SPIE<=1, priv<={1'b0,SPP}, SPP<=0, MPRV<=0.
- SRET, illegal case: no state change; sret_illegal pulses next cycle.
- State update timing: all state updates are registered. mstat and priv reflect an update the cycle after the event.

Decomposition:
- Shared package (csr_pkg):
  - privilege encodings PRIV_U/PRIV_S/PRIV_M;
  - csr_op encodings;
  - MSTATUS bit-position constants;
  - MSTATUS_WMASK;
  - MSTATUS_RESET.
- Sub-module mstatus_warl: pure combinational legaliser (old, proposed, params) -> legal value, reused by the future sstatus view.

Test Plan:
- Reset release -> mstat=32'h0000_1800, priv=11, csr_ready=1, all pulses 0.
- csr_valid, op=set, wdata=32'h0000_0008 -> csr_rdata=32'h0000_1800, csr_done one cycle later, mstat=32'h0000_1808.
- MIE=1, priv=11, trap_take -> mstat=32'h0000_1880 (MPIE=1, MIE=0, MPP=11); then mret -> mstat=32'h0000_0088, priv=11.
- op=write, wdata=32'h0000_1000 (MPP=10) -> MPP stays 11, mstat[12:11]=11, csr_done pulses.
- csr_valid accepted, trap_take asserted in APPLY cycle -> csr_drop=1, csr_done=0, trap state applied, write value absent.
- priv=01, TSR=1, sret -> sret_illegal pulses, priv stays 01; with fs_dirty=1 the same cycle -> FS=11, mstat[31]=1.

Source files
------------

// File: rtl/csr_pkg.sv
// csr_pkg: shared CSR-unit constants (privilege and csr_op encodings, mstatus layout, masks, FSM states)
package csr_pkg;
    localparam logic [1:0] PRIV_U = 2'b00;
    localparam logic [1:0] PRIV_S = 2'b01;
    localparam logic [1:0] PRIV_M = 2'b11;

    typedef enum logic [1:0] {
        OP_NOP   = 2'b00,
        OP_WRITE = 2'b01,
        OP_SET   = 2'b10,
        OP_CLEAR = 2'b11
    } csr_op_e;

    localparam int B_SIE  = 1;
    localparam int B_MIE  = 3;
    localparam int B_SPIE = 5;
    localparam int B_MPIE = 7;
    localparam int B_SPP  = 8;
    localparam int B_MPRV = 17;
    localparam int B_TSR  = 22;

    // Every software-writable stored bit; TW, XS, UIE, UPIE and SD are never stored.
    localparam logic [31:0] MSTATUS_WMASK = 32'h005E_79AA;
    // Supervisor-only bits: SIE, SPIE, SPP, SUM, MXR, TVM, TSR.
    localparam logic [31:0] MSTATUS_SMASK = 32'h005C_0122;
    localparam logic [31:0] MSTATUS_MPRV  = 32'h0002_0000;
    localparam logic [31:0] MSTATUS_RESET = 32'h0000_1800;

    typedef enum logic {IDLE, APPLY} state_e;
endpackage

// File: rtl/mstatus_ctrl_if.sv
// mstatus_ctrl_if: CSR-instruction port of the mstatus block
//   master drives csr_valid/csr_op/csr_wdata; slave returns csr_ready/csr_rdata/csr_done/csr_drop
interface mstatus_ctrl_if;
    logic        csr_valid;
    logic        csr_ready;
    logic [1:0]  csr_op;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        csr_done;
    logic        csr_drop;

    modport master (output csr_valid, csr_op, csr_wdata,
                    input  csr_ready, csr_rdata, csr_done, csr_drop);
    modport slave  (input  csr_valid, csr_op, csr_wdata,
                    output csr_ready, csr_rdata, csr_done, csr_drop);
endinterface

// File: rtl/mstatus_warl.sv
// mstatus_warl: combinational legaliser turning a proposed status value into a legal one
//   old_i   : current stored value (source for non-writable bits and rejected MPP)
//   prop_i  : proposed value from the CSR instruction
//   legal_o : value to commit
module mstatus_warl
    import csr_pkg::*;
#(
    parameter bit SUPPORT_S = 1'b1,
    parameter bit SUPPORT_U = 1'b1
) (
    input  logic [31:0] old_i,
    input  logic [31:0] prop_i,
    output logic [31:0] legal_o
);
    logic [31:0] wmask;
    logic [1:0]  mpp_p;
    logic        keep_mpp;

    always_comb begin
        wmask    = MSTATUS_WMASK & ~(SUPPORT_S ? 32'h0 : MSTATUS_SMASK)
                                 & ~(SUPPORT_U ? 32'h0 : MSTATUS_MPRV);
        mpp_p    = prop_i[12:11];
        keep_mpp = (mpp_p == 2'b10) || (mpp_p == PRIV_S && !SUPPORT_S)
                || (mpp_p != PRIV_M && !SUPPORT_U);
        legal_o  = (prop_i & wmask) | (old_i & ~wmask);
        legal_o[12:11] = keep_mpp ? old_i[12:11] : mpp_p;
    end
endmodule

// File: rtl/mstatus_ctrl.sv
// mstatus_ctrl: mstatus state and privilege owner; applies CSR writes, trap entry, MRET and SRET
//   clk, rst (async, active-low)
//   csr          : CSR-instruction port (slave), 1-cycle capture->commit pipeline
//   trap_take, mret, sret, fs_dirty : event pulses from trap controller / FPU
//   sret_illegal : registered pulse for a rejected SRET
//   priv, mstat  : current privilege and packed mstatus image
module mstatus_ctrl
    import csr_pkg::*;
#(
    parameter bit         SUPPORT_S  = 1'b1,
    parameter bit         SUPPORT_U  = 1'b1,
    parameter logic [1:0] RESET_PRIV = 2'b11
) (
    input  logic                 clk,
    input  logic                 rst,
    mstatus_ctrl_if.slave        csr,
    input  logic                 trap_take,
    input  logic                 mret,
    input  logic                 sret,
    input  logic                 fs_dirty,
    output logic                 sret_illegal,
    output logic [1:0]           priv,
    output logic [31:0]          mstat
);
    state_e      state_q, state_d;
    logic [31:0] st_q, st_d;
    logic [1:0]  priv_q, priv_d;
    logic        done_q, done_d, drop_q, drop_d, ill_q, ill_d;
    logic [1:0]  op_q;
    logic [31:0] wdata_q, rdata_q;
    logic [31:0] prop, legal;
    logic        evt, commit, sret_ok, fs_written;

    mstatus_warl #(.SUPPORT_S(SUPPORT_S), .SUPPORT_U(SUPPORT_U)) u_warl (
        .old_i   (st_q),
        .prop_i  (prop),
        .legal_o (legal)
    );

    always_comb begin
        prop = op_q == OP_WRITE ? wdata_q
             : op_q == OP_SET   ? st_q | wdata_q
             : op_q == OP_CLEAR ? st_q & ~wdata_q
             : st_q;
        evt        = trap_take | mret | sret;
        commit     = state_q == APPLY && !evt;
        sret_ok    = priv_q == PRIV_M || (priv_q == PRIV_S && !st_q[B_TSR]);
        // An explicit FS write in the committing instruction beats the FPU's dirty mark.
        fs_written = op_q == OP_WRITE || (op_q != OP_NOP && |wdata_q[14:13]);
        state_d = (state_q == IDLE && csr.csr_valid) ? APPLY : IDLE;
        st_d    = st_q;
        priv_d  = priv_q;
        done_d  = commit;
        drop_d  = state_q == APPLY && evt;
        ill_d   = 1'b0;
        if (trap_take) begin
            st_d[B_MPIE]  = st_q[B_MIE];
            st_d[B_MIE]   = 1'b0;
            st_d[12:11]   = priv_q;
            priv_d        = PRIV_M;
        end else if (mret) begin
            st_d[B_MIE]   = st_q[B_MPIE];
            st_d[B_MPIE]  = 1'b1;
            priv_d        = st_q[12:11];
            st_d[12:11]   = SUPPORT_U ? PRIV_U : PRIV_M;
            if (st_q[12:11] != PRIV_M) st_d[B_MPRV] = 1'b0;
        end else if (sret) begin
            if (sret_ok) begin
                st_d[B_SIE]   = st_q[B_SPIE];
                st_d[B_SPIE]  = SUPPORT_S;
                priv_d        = {1'b0, st_q[B_SPP]};
                st_d[B_SPP]   = 1'b0;
                st_d[B_MPRV]  = 1'b0;
            end else begin
                ill_d = 1'b1;
            end
        end else if (commit) begin
            st_d = legal;
        end
        if (fs_dirty && !(commit && fs_written)) st_d[14:13] = 2'b11;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            st_q    <= MSTATUS_RESET;
            priv_q  <= RESET_PRIV;
            done_q  <= 1'b0;
            drop_q  <= 1'b0;
            ill_q   <= 1'b0;
            op_q    <= 2'b00;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            st_q    <= st_d;
            priv_q  <= priv_d;
            done_q  <= done_d;
            drop_q  <= drop_d;
            ill_q   <= ill_d;
            if (state_q == IDLE && csr.csr_valid) begin
                op_q    <= csr.csr_op;
                wdata_q <= csr.csr_wdata;
                rdata_q <= mstat;
            end
        end
    end

    // XS is hardwired 0, so SD only tracks a dirty FS.
    assign mstat         = st_q | {st_q[14:13] == 2'b11, 31'b0};
    assign priv          = priv_q;
    assign sret_illegal  = ill_q;
    assign csr.csr_ready = state_q == IDLE;
    assign csr.csr_rdata = rdata_q;
    assign csr.csr_done  = done_q;
    assign csr.csr_drop  = drop_q;
endmodule

// File: tb/tb_mstatus_ctrl.sv
// tb_mstatus_ctrl: directed table, corner sequences and randomized run against a field-level model
module tb_mstatus_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        trap_take = 1'b0, mret = 1'b0, sret = 1'b0, fs_dirty = 1'b0;
    logic        sret_illegal;
    logic [1:0]  priv;
    logic [31:0] mstat;
    int          total = 0, passed = 0;

    mstatus_ctrl_if bus ();

    mstatus_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .csr          (bus),
        .trap_take    (trap_take),
        .mret         (mret),
        .sret         (sret),
        .fs_dirty     (fs_dirty),
        .sret_illegal (sret_illegal),
        .priv         (priv),
        .mstat        (mstat)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit mie, sie, mpie, spie, spp, mprv, sum, mxr, tvm, tsr;
        bit [1:0] mpp, fs, priv;
    } ms_t;

    ms_t       m;
    bit        pend;
    bit [1:0]  p_op;
    bit [31:0] p_wd, e_rdata;
    bit        e_done, e_drop, e_ill;

    function automatic bit [31:0] img(ms_t s);
        bit [31:0] r;
        r = 32'h0;
        r[31] = s.fs == 2'b11;  r[22] = s.tsr;  r[20] = s.tvm;  r[19] = s.mxr;
        r[18] = s.sum;  r[17] = s.mprv;  r[14:13] = s.fs;  r[12:11] = s.mpp;
        r[8] = s.spp;  r[7] = s.mpie;  r[5] = s.spie;  r[3] = s.mie;  r[1] = s.sie;
        return r;
    endfunction

    task automatic model_reset();
        m = '{default: 0};
        m.mpp = 2'b11;
        m.priv = 2'b11;
        pend = 0; p_op = 0; p_wd = 0; e_rdata = 0;
        e_done = 0; e_drop = 0; e_ill = 0;
    endtask

    task automatic model_step(input bit v, input bit [1:0] op, input bit [31:0] wd,
                              input bit tr, input bit mr, input bit sr, input bit fd);
        bit [31:0] cur, nv;
        bit        cm, ev;
        cur = img(m);
        ev  = tr | mr | sr;
        cm  = pend && !ev;
        e_done = cm; e_drop = pend && ev; e_ill = 0;
        if (tr) begin
            m.mpie = m.mie; m.mie = 0; m.mpp = m.priv; m.priv = 2'b11;
        end else if (mr) begin
            m.mie = m.mpie; m.mpie = 1; m.priv = m.mpp;
            if (m.mpp != 2'b11) m.mprv = 0;
            m.mpp = 2'b00;
        end else if (sr) begin
            if (m.priv == 2'b11 || (m.priv == 2'b01 && !m.tsr)) begin
                m.sie = m.spie; m.spie = 1; m.priv = {1'b0, m.spp}; m.spp = 0; m.mprv = 0;
            end else e_ill = 1;
        end else if (cm) begin
            case (p_op)
                2'b01:   nv = p_wd;
                2'b10:   nv = cur | p_wd;
                2'b11:   nv = cur & ~p_wd;
                default: nv = cur;
            endcase
            m.mie = nv[3]; m.sie = nv[1]; m.mpie = nv[7]; m.spie = nv[5]; m.spp = nv[8];
            m.mprv = nv[17]; m.sum = nv[18]; m.mxr = nv[19]; m.tvm = nv[20]; m.tsr = nv[22];
            m.fs = nv[14:13];
            if (nv[12:11] != 2'b10) m.mpp = nv[12:11];
        end
        if (fd && !(cm && (p_op == 2'b01 || (p_op != 2'b00 && p_wd[14:13] != 2'b00)))) m.fs = 2'b11;
        if (!pend && v) begin
            e_rdata = cur; pend = 1; p_op = op; p_wd = wd;
        end else pend = 0;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else passed++;
    endtask

    task automatic cycle(input bit v, input bit [1:0] op, input bit [31:0] wd,
                         input bit tr, input bit mr, input bit sr, input bit fd);
        bus.csr_valid = v; bus.csr_op = op; bus.csr_wdata = wd;
        trap_take = tr; mret = mr; sret = sr; fs_dirty = fd;
        model_step(v, op, wd, tr, mr, sr, fd);
        @(negedge clk);
    endtask

    task automatic check_model(input string name);
        check({name, "_state"}, {mstat, priv, bus.csr_ready, bus.csr_done, bus.csr_drop, sret_illegal},
              {img(m), m.priv, !pend, e_done, e_drop, e_ill});
        check({name, "_rdata"}, bus.csr_rdata, e_rdata);
    endtask

    typedef struct {
        bit v; bit [1:0] op; bit [31:0] wd; bit tr, mr, sr, fd;
        bit [31:0] e_mstat; bit [1:0] e_priv; bit e_done, e_drop, e_ill;
    } vec_t;

    vec_t vt[18];

    initial begin
        vt[0]  = '{1, 2'b10, 32'h0000_0008, 0, 0, 0, 0, 32'h0000_1800, 2'b11, 0, 0, 0};
        vt[1]  = '{0, 2'b00, 32'h0,         0, 0, 0, 0, 32'h0000_1808, 2'b11, 1, 0, 0};
        vt[2]  = '{1, 2'b01, 32'h0000_1008, 0, 0, 0, 0, 32'h0000_1808, 2'b11, 0, 0, 0};
        vt[3]  = '{0, 2'b00, 32'h0,         0, 0, 0, 0, 32'h0000_1808, 2'b11, 1, 0, 0};
        vt[4]  = '{0, 2'b00, 32'h0,         1, 0, 0, 0, 32'h0000_1880, 2'b11, 0, 0, 0};
        vt[5]  = '{0, 2'b00, 32'h0,         0, 1, 0, 0, 32'h0000_0088, 2'b11, 0, 0, 0};
        vt[6]  = '{1, 2'b01, 32'hFFFF_FFFF, 0, 0, 0, 0, 32'h0000_0088, 2'b11, 0, 0, 0};
        vt[7]  = '{0, 2'b00, 32'h0,         1, 0, 0, 0, 32'h0000_1880, 2'b11, 0, 1, 0};
        vt[8]  = '{1, 2'b01, 32'h0040_0800, 0, 0, 0, 0, 32'h0000_1880, 2'b11, 0, 0, 0};
        vt[9]  = '{0, 2'b00, 32'h0,         0, 0, 0, 0, 32'h0040_0800, 2'b11, 1, 0, 0};
        vt[10] = '{0, 2'b00, 32'h0,         0, 1, 0, 0, 32'h0040_0080, 2'b01, 0, 0, 0};
        vt[11] = '{0, 2'b00, 32'h0,         0, 0, 1, 1, 32'h8040_6080, 2'b01, 0, 0, 1};
        vt[12] = '{0, 2'b00, 32'h0,         0, 0, 0, 0, 32'h8040_6080, 2'b01, 0, 0, 0};
        vt[13] = '{1, 2'b11, 32'h0040_0000, 0, 0, 0, 0, 32'h8040_6080, 2'b01, 0, 0, 0};
        vt[14] = '{0, 2'b00, 32'h0,         0, 0, 0, 0, 32'h8000_6080, 2'b01, 1, 0, 0};
        vt[15] = '{0, 2'b00, 32'h0,         0, 0, 1, 0, 32'h8000_60A0, 2'b00, 0, 0, 0};
        vt[16] = '{0, 2'b00, 32'h0,         0, 0, 1, 0, 32'h8000_60A0, 2'b00, 0, 0, 1};
        vt[17] = '{0, 2'b00, 32'h0,         1, 0, 0, 0, 32'h8000_6020, 2'b11, 0, 0, 0};

        bus.csr_valid = 0; bus.csr_op = 0; bus.csr_wdata = 0;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1;
        check("reset_mstat", mstat, 32'h0000_1800);
        check("reset_priv", priv, 2'b11);
        check("reset_ready", bus.csr_ready, 1'b1);
        check("reset_pulses", {bus.csr_done, bus.csr_drop, sret_illegal}, 3'b000);

        for (int i = 0; i < 18; i++) begin
            cycle(vt[i].v, vt[i].op, vt[i].wd, vt[i].tr, vt[i].mr, vt[i].sr, vt[i].fd);
            check($sformatf("vec%0d", i),
                  {mstat, priv, bus.csr_done, bus.csr_drop, sret_illegal},
                  {vt[i].e_mstat, vt[i].e_priv, vt[i].e_done, vt[i].e_drop, vt[i].e_ill});
            if (i == 0) check("vec0_rdata", bus.csr_rdata, 32'h0000_1800);
            if (i == 0) check("vec0_busy", bus.csr_ready, 1'b0);
        end

        // Asynchronous reset while a write sits in APPLY: discarded with no drop pulse.
        bus.csr_valid = 1; bus.csr_op = 2'b01; bus.csr_wdata = 32'hFFFF_FFFF;
        trap_take = 0; mret = 0; sret = 0; fs_dirty = 0;
        @(posedge clk);
        #2 rst = 0; bus.csr_valid = 0;
        #1;
        check("midop_reset", {mstat, priv, bus.csr_ready, bus.csr_done, bus.csr_drop, sret_illegal},
              {32'h0000_1800, 2'b11, 1'b1, 3'b000});
        @(negedge clk);
        rst = 1;
        model_reset();
        cycle(0, 0, 0, 0, 0, 0, 0);
        check_model("post_reset");

        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(2) == 0, 2'($urandom), $urandom,
                  $urandom_range(15) == 0, $urandom_range(11) == 0,
                  $urandom_range(9) == 0, $urandom_range(7) == 0);
            check_model($sformatf("rand%0d", i));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
